// File: rtl/bumpy_motion_fsm.sv
// Bumpy player-motion FSM: key/collision driven moves, frame-timed jump/bounce/death, game-over lock.
// Optional life counter with respawn is enabled by defining BUMPY_RESPAWN_EN.
module bumpy_motion_fsm #(
  parameter int unsigned TILE_W        = 3,
  parameter int unsigned FREE_CODE     = 0,
  parameter int unsigned DEATH_CODE    = 3,
  parameter int unsigned WALL_CODE     = 4,
  parameter int unsigned JUMP_FRAMES   = 16,
  parameter int unsigned BOUNCE_FRAMES = 8,
  parameter int unsigned DIE_FRAMES    = 32,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned LIFE_W        = 2,
  parameter int unsigned TIMER_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  up_keyN,
  input  logic                  left_keyN,
  input  logic                  right_keyN,
  input  logic                  down_keyN,
  input  logic                  bumpy_collision,
  input  logic [3:0]            hit_edge,
  input  logic [4*TILE_W-1:0]   area,
  output logic [3:0]            state,
  output logic [LIFE_W-1:0]     lives,
  output logic                  game_over,
  output logic                  die_pulse
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_IDLE     = 4'd1,
    S_LEFT     = 4'd2,
    S_RIGHT    = 4'd3,
    S_DOWN     = 4'd4,
    S_UP       = 4'd5,
    S_DIE      = 4'd6,
    S_BOUNCE_L = 4'd7,
    S_BOUNCE_R = 4'd8,
    S_BOUNCE_T = 4'd9,
    S_OVER     = 4'd10
  } state_t;

  state_t             state_q, state_d, key_next;
  logic [TIMER_W-1:0] timer_q, timer_init;
  logic               die_pulse_q;
  logic               load, timed_d;

  logic [TILE_W-1:0] tile_left, tile_up, tile_right, tile_down;
  assign tile_left  = area[0*TILE_W +: TILE_W];
  assign tile_up    = area[1*TILE_W +: TILE_W];
  assign tile_right = area[2*TILE_W +: TILE_W];
  assign tile_down  = area[3*TILE_W +: TILE_W];

  logic land, death, any_key, expire;
  assign land    = bumpy_collision && (hit_edge == 4'b0001);
  assign death   = (tile_down == TILE_W'(DEATH_CODE));
  assign any_key = !(up_keyN && left_keyN && right_keyN && down_keyN);
  assign expire  = frame_tick && (timer_q == TIMER_W'(1));

  logic unused_free;
  assign unused_free = (FREE_CODE != 0);

`ifdef BUMPY_RESPAWN_EN
  logic [LIFE_W-1:0] lives_q;
  logic              lives_dec, lives_clr;
`else
  logic unused_lives;
  assign unused_lives = (LIVES != 0);
`endif

  always_comb begin
    key_next = S_IDLE;
    if (!up_keyN)
      key_next = (tile_up == TILE_W'(WALL_CODE)) ? S_BOUNCE_T : S_UP;
    else if (!left_keyN)
      key_next = (tile_left == TILE_W'(WALL_CODE)) ? S_BOUNCE_L : S_LEFT;
    else if (!right_keyN)
      key_next = (tile_right == TILE_W'(WALL_CODE)) ? S_BOUNCE_R : S_RIGHT;
  end

  // load marks any taken transition, so re-entering the same timed state reloads its timer
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
`ifdef BUMPY_RESPAWN_EN
    lives_dec = 1'b0;
    lives_clr = 1'b0;
`endif
    case (state_q)
      S_RESET: if (any_key) state_d = S_DOWN;
      S_IDLE, S_LEFT, S_RIGHT, S_DOWN: begin
        if (death)     begin state_d = S_DIE;    load = 1'b1; end
        else if (land) begin state_d = key_next; load = 1'b1; end
      end
      S_UP: begin
        if (death)                                  begin state_d = S_DIE;      load = 1'b1; end
        else if (tile_up == TILE_W'(WALL_CODE))     begin state_d = S_BOUNCE_T; load = 1'b1; end
        else if (land)                              begin state_d = key_next;   load = 1'b1; end
        else if (expire)                            begin state_d = S_DOWN;     load = 1'b1; end
      end
      S_BOUNCE_L, S_BOUNCE_R, S_BOUNCE_T: begin
        if (death)       begin state_d = S_DIE;    load = 1'b1; end
        else if (land)   begin state_d = key_next; load = 1'b1; end
        else if (expire) begin state_d = S_DOWN;   load = 1'b1; end
      end
      S_DIE: begin
        if (expire) begin
          load = 1'b1;
`ifdef BUMPY_RESPAWN_EN
          if (lives_q > LIFE_W'(1)) begin state_d = S_RESET; lives_dec = 1'b1; end
          else                      begin state_d = S_OVER;  lives_clr = 1'b1; end
`else
          state_d = S_OVER;
`endif
        end
      end
      S_OVER: state_d = S_OVER;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    timer_init = '0;
    timed_d    = 1'b1;
    case (state_d)
      S_UP:                               timer_init = TIMER_W'(JUMP_FRAMES);
      S_BOUNCE_L, S_BOUNCE_R, S_BOUNCE_T: timer_init = TIMER_W'(BOUNCE_FRAMES);
      S_DIE:                              timer_init = TIMER_W'(DIE_FRAMES);
      default:                            timed_d    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      timer_q     <= '0;
      die_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      die_pulse_q <= (state_d == S_DIE) && (state_q != S_DIE);
      if (load || !timed_d)
        timer_q <= timer_init;
      else if (frame_tick && timer_q != '0)
        timer_q <= timer_q - TIMER_W'(1);
    end
  end

`ifdef BUMPY_RESPAWN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          lives_q <= LIFE_W'(LIVES);
    else if (lives_dec) lives_q <= lives_q - LIFE_W'(1);
    else if (lives_clr) lives_q <= '0;
  end
  assign lives = lives_q;
`else
  assign lives = '0;
`endif

  assign state     = state_q;
  assign game_over = (state_q == S_OVER);
  assign die_pulse = die_pulse_q;

endmodule

// File: tb/tb_bumpy_motion_fsm.sv
// Directed self-checking bench for bumpy_motion_fsm (default parameters, either BUMPY_RESPAWN_EN setting).
module tb_bumpy_motion_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        up_keyN = 1'b1, left_keyN = 1'b1, right_keyN = 1'b1, down_keyN = 1'b1;
  logic        bumpy_collision = 1'b0;
  logic [3:0]  hit_edge = 4'b0000;
  logic [11:0] area = '0;
  logic [3:0]  state;
  logic [1:0]  lives;
  logic        game_over;
  logic        die_pulse;

  int total = 0;
  int bad   = 0;

`ifdef BUMPY_RESPAWN_EN
  localparam logic [1:0] RESET_LIVES = 2'd3;
`else
  localparam logic [1:0] RESET_LIVES = 2'd0;
`endif

  bumpy_motion_fsm dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .up_keyN(up_keyN), .left_keyN(left_keyN), .right_keyN(right_keyN), .down_keyN(down_keyN),
    .bumpy_collision(bumpy_collision), .hit_edge(hit_edge), .area(area),
    .state(state), .lives(lives), .game_over(game_over), .die_pulse(die_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic idle_inputs();
    up_keyN = 1'b1; left_keyN = 1'b1; right_keyN = 1'b1; down_keyN = 1'b1;
    bumpy_collision = 1'b0; hit_edge = 4'b0000; area = '0; frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (lives !== RESET_LIVES) begin bad++; $display("FAIL reset_lives got=%0d want=%0d", lives, RESET_LIVES); end
    total++; if (game_over !== 1'b0 || die_pulse !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", game_over, die_pulse); end
  endtask

  task automatic test_reset_exit();
    left_keyN = 1'b0;
    step(1);
    left_keyN = 1'b1;
    total++; if (state !== 4'd4) begin bad++; $display("FAIL reset_exit got=%0d want=4", state); end
  endtask

  task automatic test_bounce_r();
    right_keyN = 1'b0; bumpy_collision = 1'b1; hit_edge = 4'b0001; area[8:6] = 3'd4;
    step(1);
    idle_inputs();
    total++; if (state !== 4'd8) begin bad++; $display("FAIL bounce_r_entry got=%0d want=8", state); end
    repeat (7) tick();
    total++; if (state !== 4'd8) begin bad++; $display("FAIL bounce_r_7ticks got=%0d want=8", state); end
    tick();
    total++; if (state !== 4'd4) begin bad++; $display("FAIL bounce_r_expiry got=%0d want=4", state); end
  endtask

  task automatic test_jump();
    up_keyN = 1'b0; bumpy_collision = 1'b1; hit_edge = 4'b0001;
    step(1);
    idle_inputs();
    total++; if (state !== 4'd5) begin bad++; $display("FAIL jump_entry got=%0d want=5", state); end
    repeat (15) tick();
    total++; if (state !== 4'd5) begin bad++; $display("FAIL jump_15ticks got=%0d want=5", state); end
    tick();
    total++; if (state !== 4'd4) begin bad++; $display("FAIL jump_expiry got=%0d want=4", state); end
    up_keyN = 1'b0; bumpy_collision = 1'b1; hit_edge = 4'b0001;
    step(1);
    idle_inputs();
    repeat (9) tick();
    left_keyN = 1'b0; bumpy_collision = 1'b1; hit_edge = 4'b0001;
    tick();
    idle_inputs();
    total++; if (state !== 4'd2) begin bad++; $display("FAIL jump_land_10th got=%0d want=2", state); end
  endtask

  task automatic test_death();
    area[11:9] = 3'd3; bumpy_collision = 1'b1; hit_edge = 4'b0001; right_keyN = 1'b0;
    step(1);
    idle_inputs();
    total++; if (state !== 4'd6) begin bad++; $display("FAIL death_entry got=%0d want=6", state); end
    total++; if (die_pulse !== 1'b1) begin bad++; $display("FAIL die_pulse_first got=%b want=1", die_pulse); end
    step(1);
    total++; if (die_pulse !== 1'b0) begin bad++; $display("FAIL die_pulse_second got=%b want=0", die_pulse); end
    repeat (31) tick();
    total++; if (state !== 4'd6) begin bad++; $display("FAIL die_31ticks got=%0d want=6", state); end
    tick();
`ifdef BUMPY_RESPAWN_EN
    total++; if (state !== 4'd0) begin bad++; $display("FAIL die_respawn got=%0d want=0", state); end
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL die_lives got=%0d want=2", lives); end
`else
    total++; if (state !== 4'd10) begin bad++; $display("FAIL die_over got=%0d want=10", state); end
    total++; if (lives !== 2'd0) begin bad++; $display("FAIL die_lives got=%0d want=0", lives); end
`endif
  endtask

  task automatic die_from_reset();
    left_keyN = 1'b0;
    step(1);
    left_keyN = 1'b1;
    area[11:9] = 3'd3;
    step(1);
    idle_inputs();
    repeat (32) tick();
  endtask

  task automatic test_game_over();
`ifdef BUMPY_RESPAWN_EN
    die_from_reset();
    total++; if (state !== 4'd0 || lives !== 2'd1) begin bad++; $display("FAIL second_death got=%0d/%0d want=0/1", state, lives); end
    die_from_reset();
`endif
    total++; if (state !== 4'd10) begin bad++; $display("FAIL over_state got=%0d want=10", state); end
    total++; if (lives !== 2'd0 || game_over !== 1'b1) begin bad++; $display("FAIL over_flags got=%0d/%b want=0/1", lives, game_over); end
    up_keyN = 1'b0; left_keyN = 1'b0; down_keyN = 1'b0; bumpy_collision = 1'b1; hit_edge = 4'b0001;
    tick();
    step(3);
    idle_inputs();
    total++; if (state !== 4'd10) begin bad++; $display("FAIL over_sticky got=%0d want=10", state); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    total++; if (state !== 4'd0 || lives !== RESET_LIVES || game_over !== 1'b0) begin
      bad++; $display("FAIL over_reset got=%0d/%0d/%b want=0/%0d/0", state, lives, game_over, RESET_LIVES); end
  endtask

  task automatic test_async_reset_mid_up();
    down_keyN = 1'b0;
    step(1);
    down_keyN = 1'b1;
    total++; if (state !== 4'd4) begin bad++; $display("FAIL down_key_exit got=%0d want=4", state); end
    up_keyN = 1'b0; bumpy_collision = 1'b1; hit_edge = 4'b0001;
    step(1);
    idle_inputs();
    repeat (3) tick();
    total++; if (state !== 4'd5) begin bad++; $display("FAIL up_before_reset got=%0d want=5", state); end
    #2 reset = 1'b1;
    #1;
    total++; if (state !== 4'd0 || lives !== RESET_LIVES) begin
      bad++; $display("FAIL async_reset got=%0d/%0d want=0/%0d", state, lives, RESET_LIVES); end
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_reset_exit();
    test_bounce_r();
    test_jump();
    test_death();
    test_game_over();
    test_async_reset_mid_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bumpy_motion_fsm.md
# bumpy_motion_fsm

Parametrised player-motion controller for the Bumpy character: second-generation movement FSM with configurable tile-code width, frame-timed jump/bounce/death phases, a life counter and a game-over lock. Sits between the keypad/collision logic and the Bumpy move/draw blocks; its `state` output selects the speed profile applied by the mover each frame.

## Interface
- `TILE_W`, 3: width of each tile-type code in `area`
- `FREE_CODE`/`DEATH_CODE`/`WALL_CODE`, 0/3/4: tile codes (TILE_W bits)
- `JUMP_FRAMES`, 16: frame ticks spent in UP before falling (≥1)
- `BOUNCE_FRAMES`, 8: frame ticks spent in any BOUNCE state (≥1)
- `DIE_FRAMES`, 32: frame ticks spent in DIE (≥1)
- `LIVES`, 3: lives loaded at reset (1..2^LIFE_W−1)
- `LIFE_W`, 2: width of `lives`
- `TIMER_W`, 8: phase-timer width; all *_FRAMES < 2^TIMER_W
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse per video frame
- `up_keyN`, `left_keyN`, `right_keyN`, `down_keyN` in 1 each: keys, active-low
- `bumpy_collision` in 1: Bumpy overlaps a solid tile this cycle
- `hit_edge` in 4: {Left,Top,Right,Bottom} one-hot hit edge
- `area` in 4×TILE_W: [0]=left, [1]=up, [2]=right, [3]=down neighbour tile code
- `state` out 4: current state code
- `lives` out LIFE_W: remaining lives
- `game_over` out 1: high in OVER
- `die_pulse` out 1: one-cycle pulse on entry to DIE

## Operation
- Encodings: RESET=0, IDLE=1, LEFT=2, RIGHT=3, DOWN=4, UP=5, DIE=6, BOUNCE_L=7, BOUNCE_R=8, BOUNCE_T=9, OVER=10; 11–15 illegal → RESET next cycle.
- land = bumpy_collision && hit_edge==4'b0001.
- key decode (priority up>left>right): up → UP, or BOUNCE_T if area[1]==WALL; left → LEFT, or BOUNCE_L if area[0]==WALL; right → RIGHT, or BOUNCE_R if area[2]==WALL; none → IDLE. Down key only used for RESET exit.
- RESET: any key pressed → DOWN; else hold.
- Death check (all states except RESET/DIE/OVER), highest priority: area[3]==DEATH → DIE.
- IDLE/LEFT/RIGHT/DOWN: land → key decode; else hold.
- UP: area[1]==WALL → BOUNCE_T; else land → key decode; else timer expiry → DOWN.
- BOUNCE_L/R/T: land → key decode; else timer expiry → DOWN.
- DIE: timer expiry → if lives>1: lives−1, RESET; if lives==1: lives=0, OVER.
- OVER: sticky until `reset`.
- Phase timer: loaded with N (JUMP/BOUNCE/DIE_FRAMES) on every entry to UP/BOUNCE_*/DIE, including re-entry; decrements on frame_tick while in that state; expiry = frame_tick while timer==1 (exactly N ticks in state).

## Timing
- Registered state; transitions take effect the cycle after the qualifying inputs.
- Reset values: state=0, lives=LIVES, game_over=0, die_pulse=0, timer=0.
- Priority in one cycle: death > wall bounce (UP only) > land > timer expiry.
- die_pulse registered, high in the first DIE cycle only.
- game_over = (state==OVER), combinational from state.
- Reset asserted mid-DIE or mid-UP: immediate return to reset values; lives restored to LIVES.
- frame_tick outside timed states ignored; no timer wrap (load ≥1).

## Configuration
- `BUMPY_RESPAWN_EN` defined: life counter and respawn as above.
- Not defined: no life counter; DIE expiry always → OVER; `lives` tied to 0.

## Test plan
- Reset, all keys high 10 cycles → state=0, lives=3; pulse left_keyN low → state=4 next cycle.
- DOWN, land with right key, area[2]=4 → state=8; 8 frame_ticks without land → state=4.
- Land with up key, area[1]=0, JUMP_FRAMES=16 → state=5; after 16th frame_tick → state=4; land on 10th tick instead → key decode wins.
- LEFT, area[3]=3 and land same cycle → state=6, die_pulse one cycle; 32 ticks → state=0, lives=2.
- Three deaths → lives=0, state=10, game_over=1; keys ignored; reset → state=0, lives=3.
- Macro undefined: first death expiry → state=10, lives=0.
